// File: rtl/fft64_stride_reorder.sv
// Input reorder stage for the 64-point radix-8 FFT.
// Ping-pong frame buffer: natural-order writes, stride-8 group reads.
module fft64_stride_reorder #(
  parameter int unsigned W = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_re,
  input  logic [W-1:0]   in_im,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [8*W-1:0] out_re,
  output logic [8*W-1:0] out_im,
  output logic [2:0]     out_grp,
  output logic           out_last
);

  localparam int unsigned DEPTH = 64;
  localparam int unsigned NGRP  = 8;
  localparam int unsigned DW    = 2 * W;
  localparam int unsigned IDXW  = 6;
  localparam int unsigned GRPW  = 3;

  logic [DW-1:0]   bank_q [2][DEPTH];
  logic [1:0]      full_q,   full_d;
  logic            wr_sel_q, wr_sel_d;
  logic            rd_sel_q, rd_sel_d;
  logic [IDXW-1:0] wr_idx_q, wr_idx_d;
  logic [GRPW-1:0] rd_grp_q, rd_grp_d;

  logic            wr_fire_c;
  logic            rd_fire_c;
  logic [DW-1:0]   rd_word;

  assign in_ready  = ~full_q[wr_sel_q];
  assign out_valid = full_q[rd_sel_q];
  assign out_grp   = rd_grp_q;
  assign out_last  = (rd_grp_q == GRPW'(NGRP - 1));

  assign wr_fire_c = in_valid & ~full_q[wr_sel_q];
  assign rd_fire_c = out_ready & full_q[rd_sel_q];

  // Write bank is never full and read bank is always full, so the two flag
  // updates below always land on different banks.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_idx_d = wr_idx_q;
    rd_grp_d = rd_grp_q;
    if (wr_fire_c) begin
      wr_idx_d = wr_idx_q + IDXW'(1);
      if (wr_idx_q == IDXW'(DEPTH - 1)) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
      end
    end
    if (rd_fire_c) begin
      rd_grp_d = rd_grp_q + GRPW'(1);
      if (rd_grp_q == GRPW'(NGRP - 1)) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_idx_q <= '0;
      rd_grp_q <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_idx_q <= wr_idx_d;
      rd_grp_q <= rd_grp_d;
    end
  end

  // Sample storage is not reset; contents are only observed once a bank is full.
  always_ff @(posedge clk) begin
    if (wr_fire_c && !rst) begin
      bank_q[wr_sel_q][wr_idx_q] <= {in_re, in_im};
    end
  end

  // Slice k carries entry rd_grp + 8*k; k=0 sits in the MSB slice.
  always_comb begin
    out_re  = '0;
    out_im  = '0;
    rd_word = '0;
    for (int unsigned k = 0; k < NGRP; k++) begin
      rd_word = bank_q[rd_sel_q][{GRPW'(k), rd_grp_q}];
      out_re[(NGRP-k)*W-1 -: W] = rd_word[DW-1 -: W];
      out_im[(NGRP-k)*W-1 -: W] = rd_word[W-1:0];
    end
  end

endmodule

// File: tb/tb_fft64_stride_reorder.sv
// Scoreboard bench for fft64_stride_reorder: directed steps, frame model,
// expected groups queued at frame completion and compared at the output.
module tb_fft64_stride_reorder;

  localparam int unsigned W  = 10;
  localparam int unsigned CW = 8 * W;

  typedef struct {
    logic [CW-1:0] re;
    logic [CW-1:0] im;
    logic [2:0]    grp;
  } grp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_re;
  logic [W-1:0]  in_im;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_re;
  logic [CW-1:0] out_im;
  logic [2:0]    out_grp;
  logic          out_last;

  int checks = 0;
  int errors = 0;
  int n_groups = 0;
  int wcnt = 0;
  bit rand_mode = 1'b0;
  logic [W-1:0] fr_re [64];
  logic [W-1:0] fr_im [64];
  grp_t q [$];

  always #5 clk = ~clk;

  fft64_stride_reorder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_grp   (out_grp),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: record accepted samples, queue the 8 stride-8 groups of each full frame.
  always @(negedge clk) begin
    if (rst) begin
      wcnt = 0;
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", CW'(out_valid), CW'(1'b0));
        end else begin
          chk("out_grp",  CW'(out_grp), CW'(q[0].grp));
          chk("out_re",   out_re, q[0].re);
          chk("out_im",   out_im, q[0].im);
          chk("out_last", CW'(out_last), CW'(q[0].grp == 3'd7));
          if (out_ready) begin
            void'(q.pop_front());
            n_groups++;
          end
        end
      end
      if (in_valid && in_ready) begin
        fr_re[wcnt] = in_re;
        fr_im[wcnt] = in_im;
        wcnt++;
        if (wcnt == 64) begin
          for (int g = 0; g < 8; g++) begin
            grp_t e;
            e.grp = 3'(g);
            e.re  = '0;
            e.im  = '0;
            for (int k = 0; k < 8; k++) begin
              e.re[(8-k)*W-1 -: W] = fr_re[g + 8*k];
              e.im[(8-k)*W-1 -: W] = fr_im[g + 8*k];
            end
            q.push_back(e);
          end
          wcnt = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present one sample and hold it until accepted; returns stall cycles.
  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, output int stalls);
    bit ok;
    stalls   = 0;
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      ok = in_ready;
      step();
      if (ok) return;
      stalls++;
    end
    chk("send_timeout", CW'(in_ready), CW'(1'b1));
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      done = (q.size() == 0) && !out_valid;
      step();
    end
    if (!done) chk("drain_timeout", CW'(out_valid), CW'(1'b0));
  endtask

  initial begin
    int st;
    int tot;
    int base;
    int acc;
    int first_block;
    int seen;

    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  CW'(in_ready),  CW'(1'b1));
    chk("rst_out_valid", CW'(out_valid), CW'(1'b0));
    chk("rst_out_grp",   CW'(out_grp),   CW'(3'd0));
    chk("rst_out_last",  CW'(out_last),  CW'(1'b0));
    step();

    // 1: natural order in, stride-8 out, plus first-group latency
    out_ready = 1'b1;
    base = n_groups;
    for (int k = 0; k < 64; k++) send(W'(k), W'(-k), st);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_out_valid", CW'(out_valid), CW'(1'b1));
    chk("latency_out_grp",   CW'(out_grp),   CW'(3'd0));
    step();
    drain();
    chk("t1_groups", CW'(n_groups - base), CW'(8));

    // 2: backpressure, both banks fill, then release
    out_ready = 1'b0;
    acc = 0;
    first_block = -1;
    in_valid = 1'b1;
    for (int c = 0; c < 140; c++) begin
      in_re = W'(acc);
      in_im = W'(acc ^ 'h3FF);
      @(negedge clk);
      if (in_ready) acc++;
      else if (first_block < 0) first_block = c;
      step();
    end
    in_valid = 1'b0;
    chk("t2_accepted",    CW'(acc),         CW'(128));
    chk("t2_first_block", CW'(first_block), CW'(128));
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 40 && seen < 8; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        seen++;
        if (seen == 8) chk("t2_in_ready_at_g7", CW'(in_ready), CW'(1'b0));
      end
      step();
    end
    chk("t2_g7_reached", CW'(seen), CW'(8));
    @(negedge clk);
    chk("t2_in_ready_after_g7", CW'(in_ready), CW'(1'b1));
    step();
    drain();

    // 3: 256 samples back-to-back, no stalls expected
    base = n_groups;
    tot = 0;
    for (int k = 0; k < 256; k++) begin
      send(W'(k * 3 + 17), W'(k * 7 + 5), st);
      tot += st;
    end
    in_valid = 1'b0;
    drain();
    chk("t3_stalls", CW'(tot), CW'(0));
    chk("t3_groups", CW'(n_groups - base), CW'(32));

    // 4: random input gaps and output stalls over 10 frames
    rand_mode = 1'b1;
    base = n_groups;
    for (int k = 0; k < 640; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step();
      end
      send(W'($urandom), W'($urandom), st);
    end
    in_valid = 1'b0;
    drain();
    rand_mode = 1'b0;
    out_ready = 1'b1;
    chk("t4_groups", CW'(n_groups - base), CW'(80));

    // 5: reset with a full bank pending and a partial frame in flight
    out_ready = 1'b0;
    for (int k = 0; k < 94; k++) send(W'(k + 100), W'(k + 200), st);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_out_valid", CW'(out_valid), CW'(1'b0));
    chk("t5_in_ready",  CW'(in_ready),  CW'(1'b1));
    chk("t5_out_grp",   CW'(out_grp),   CW'(3'd0));
    step();
    out_ready = 1'b1;
    base = n_groups;
    for (int k = 0; k < 64; k++) send(W'(k + 300), W'(k + 400), st);
    in_valid = 1'b0;
    drain();
    chk("t5_groups", CW'(n_groups - base), CW'(8));

    // 6: extreme values pass bit-exact
    for (int k = 0; k < 64; k++) begin
      if (k % 2 == 0) send(10'h200, 10'h1FF, st);
      else            send(10'h1FF, 10'h200, st);
    end
    in_valid = 1'b0;
    drain();

    chk("final_queue_empty", CW'(q.size()), CW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
